seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Consumer of the calculator's 16-bit result and sign flag. It converts the unsigned magnitude to BCD with a sequential double-dabble engine, or passes raw hex nibbles through. It then drives a 6-digit multiplexed, common-anode 7-segment display, with digit 5 carrying the sign. It sits between the arithmetic/mux block and the board display pins and runs on the prescaled clock.

## Interface
- SCAN_DIV, 250: clk_prs cycles each digit stays lit. Legal range is ≥1.
- clk_prs  in  1  prescaled system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- value  in  16  unsigned magnitude to display.
- sign  in  1  producer convention: 1 = non-negative, 0 = negative.
- hex_mode  in  1  1 = show value as 4 hex digits; 0 = show it as 5 decimal digits.
- busy  out  1  high while a conversion is in progress.
- an  out  6  active-low one-hot digit enable; an[0] is the rightmost digit.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Snapshot register holds {value, sign, hex_mode} plus a snap_valid bit. Reset clears snap_valid.
- FSM states:
  - IDLE: if snap_valid=0, or any input differs from the snapshot, then capture all three inputs, set snap_valid=1, load the shift register with value, zero the BCD accumulator, set busy=1 and go to CONVERT.
  - CONVERT: runs exactly 16 cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd[19:0], shreg} left by 1. After the 16th cycle, go to UPDATE.
  - UPDATE: load the display registers, set busy=0 and go to IDLE.
- Hex mode uses the same FSM path and latency; only the UPDATE load source differs.
- Input changes while busy=1 are ignored. They are detected on the first IDLE cycle after UPDATE.
- Display register load in decimal mode:
  - Digits 0..4 take BCD nibbles 0..4.
  - Leading zeros in digits 4..1 are blanked; digit 0 is never blanked.
  - Digit 5 shows '-' if the snapshot sign is 0, otherwise blank.
- Display register load in hex mode: digits 0..3 take value nibbles [3:0]..[15:12] with no zero blanking; digits 4 and 5 are blank.
- Segment codes (gfedcba):
  - Decimal digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Hex letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Symbols: '-'=0111111, blank=1111111.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→…→5→0.
  - an and seg are registered and update on the same edge as the index.
  - Scanning runs continuously and independently of the FSM. Display registers change only in UPDATE, so a conversion never produces a torn or mixed frame.
- Width rules:
  - The BCD accumulator is 20 bits; 65535 fits in 5 digits.
  - The prescaler is $clog2(SCAN_DIV)+1 bits wide.
  - SCAN_DIV=1 advances the digit every cycle.

## Timing
- Reset values: an=111111, seg=1111111, busy=0, FSM=IDLE, snap_valid=0, digit index 0, prescaler 0, all display registers blank.
- The first edge after reset release captures inputs unconditionally because snap_valid=0.
- Latency, with inputs stable before edge E0:
  - E0: capture; busy=1.
  - E1..E16: shifts.
  - E17: display registers loaded; busy=0.
  - The new digit appears at the next scan step that selects it.
- Back-to-back input changes produce at most one conversion in flight. The final display always reflects the last input value held stable for 18 cycles.
- Reset asserted mid-conversion or mid-scan takes effect immediately and asynchronously. All outputs take their reset values and no partial result is displayed.
- The digit index wraps from 5 to 0 with no dead cycle.

## Test plan
- Reset, then value=255, sign=1, hex_mode=0, SCAN_DIV=4:
  - busy is high for edges 1..17 and low at edge 18.
  - The scan shows digit0=0010010, digit1=0010010, digit2=0100100, digits3-5=1111111.
  - an sequence is 111110, 111101, 111011, 110111, 101111, 011111, with each step lasting 4 edges.
- value=0, sign=1: digit0=1000000, all other digits blank. Then value=5, sign=0: digit0=0010010, digit5=0111111, digits1-4 blank.
- value=65535, sign=1: digits 0..4 = 5,3,5,5,6, i.e. 0010010, 0110000, 0010010, 0010010, 0000010; digit5 blank.
- hex_mode=1, value=16'hBEEF: digit0=0001110, digit1=0000110, digit2=0000110, digit3=0000011; digits4-5 blank. Latency is the same 17 edges as decimal mode.
- value=100, then value=42 three edges later while busy=1:
  - busy stays high through the first conversion and returns high on the next IDLE edge.
  - The final display shows 2,4; the value 100 is visible only transiently.
- Assert reset at CONVERT cycle 8: an=111111, seg=1111111 and busy=0 with no clock edge. After release, a fresh conversion of the current inputs completes 17 edges later.

Source files
------------

// File: rtl/seg_display_driver_if.sv
// Bundle between the calculator result producer and the 6-digit display driver.
interface seg_display_driver_if;
  logic [15:0] value;
  logic        sign;
  logic        hex_mode;
  logic        busy;
  logic [5:0]  an;
  logic [6:0]  seg;

  modport master (
    output value, sign, hex_mode,
    input  busy, an, seg
  );

  modport slave (
    input  value, sign, hex_mode,
    output busy, an, seg
  );
endinterface

// File: rtl/seg_display_driver.sv
// Converts a 16-bit magnitude to BCD (double dabble) or raw hex, and scans it
// onto a 6-digit common-anode 7-segment display with the sign on digit 5.
module seg_display_driver #(
  parameter int SCAN_DIV = 250
) (
  input logic clk_prs,
  input logic reset,
  seg_display_driver_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV) + 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  state_t      state_next;
  logic        capture;
  logic        shift_en;
  logic        load_disp;

  logic [15:0] snap_value;
  logic        snap_sign;
  logic        snap_hex;
  logic        snap_valid;

  logic [15:0] shreg;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  bit_cnt;

  logic [6:0]  disp      [6];
  logic [6:0]  disp_next [6];
  logic        leading;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [5:0]    an_r;
  logic [6:0]    seg_r;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0:    seg_code = 7'b1000000;
      4'h1:    seg_code = 7'b1111001;
      4'h2:    seg_code = 7'b0100100;
      4'h3:    seg_code = 7'b0110000;
      4'h4:    seg_code = 7'b0011001;
      4'h5:    seg_code = 7'b0010010;
      4'h6:    seg_code = 7'b0000010;
      4'h7:    seg_code = 7'b1111000;
      4'h8:    seg_code = 7'b0000000;
      4'h9:    seg_code = 7'b0010000;
      4'hA:    seg_code = 7'b0001000;
      4'hB:    seg_code = 7'b0000011;
      4'hC:    seg_code = 7'b1000110;
      4'hD:    seg_code = 7'b0100001;
      4'hE:    seg_code = 7'b0000110;
      4'hF:    seg_code = 7'b0001110;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk_prs or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control strobes; a new snapshot is taken only from IDLE
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    shift_en   = 1'b0;
    load_disp  = 1'b0;
    case (state)
      IDLE: begin
        if (!snap_valid || (bus.value != snap_value) ||
            (bus.sign != snap_sign) || (bus.hex_mode != snap_hex)) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        shift_en = 1'b1;
        if (bit_cnt == 4'd15) state_next = UPDATE;
      end
      UPDATE: begin
        load_disp  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // Add 3 to every BCD nibble that is 5 or more before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Snapshot capture and the double-dabble shift datapath
  always_ff @(posedge clk_prs or posedge reset) begin
    if (reset) begin
      snap_value <= '0;
      snap_sign  <= 1'b0;
      snap_hex   <= 1'b0;
      snap_valid <= 1'b0;
      shreg      <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
    end else if (capture) begin
      snap_value <= bus.value;
      snap_sign  <= bus.sign;
      snap_hex   <= bus.hex_mode;
      snap_valid <= 1'b1;
      shreg      <= bus.value;
      bcd        <= '0;
      bit_cnt    <= '0;
    end else if (shift_en) begin
      bcd     <= {bcd_adj[18:0], shreg[15]};
      shreg   <= {shreg[14:0], 1'b0};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Frame contents to load: hex nibbles, or BCD with leading-zero blanking and sign
  always_comb begin
    leading = 1'b1;
    for (int i = 0; i < 6; i++) disp_next[i] = SEG_BLANK;
    if (snap_hex) begin
      for (int i = 0; i < 4; i++) disp_next[i] = seg_code(snap_value[4*i +: 4]);
    end else begin
      disp_next[0] = seg_code(bcd[3:0]);
      for (int i = 4; i >= 1; i--) begin
        if (bcd[4*i +: 4] != 4'd0) leading = 1'b0;
        if (!leading) disp_next[i] = seg_code(bcd[4*i +: 4]);
      end
      if (!snap_sign) disp_next[5] = SEG_MINUS;
    end
  end

  // Display registers change only in UPDATE so the scan never sees a partial frame
  always_ff @(posedge clk_prs or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) disp[i] <= SEG_BLANK;
    end else if (load_disp) begin
      for (int i = 0; i < 6; i++) disp[i] <= disp_next[i];
    end
  end

  assign idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

  // Free-running digit scan; an, seg and the index all move on the prescaler wrap
  always_ff @(posedge clk_prs or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      an_r  <= '1;
      seg_r <= SEG_BLANK;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx_next;
      an_r  <= ~(6'b000001 << idx_next);
      seg_r <= disp[idx_next];
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver with SCAN_DIV = 4.
module tb_seg_display_driver;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] SB_ = 7'b0000011;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;

  localparam logic [18:0] TRACE_NORMAL = 19'h1FFFF;
  localparam logic [18:0] TRACE_B2B    = 19'h5FFFF;

  logic clk_prs;
  logic reset;
  int   checks;
  int   errors;

  seg_display_driver_if bus();

  seg_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_prs (clk_prs),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_prs = 1'b0;
  always #5 clk_prs = ~clk_prs;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk_prs);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic s, input logic h);
    bus.value    = v;
    bus.sign     = s;
    bus.hex_mode = h;
  endtask

  // Record busy after each of the next 19 edges
  task automatic busy_trace(output logic [18:0] trace);
    trace = '0;
    for (int n = 0; n < 19; n++) begin
      step();
      trace[n] = bus.busy;
    end
  endtask

  // Wait for idle, let one full scan refresh, then grab every digit's segments
  task automatic capture_frame(output logic [41:0] frame, output bit ok);
    int cnt;
    ok    = 1'b1;
    frame = '1;
    cnt   = 0;
    while (bus.busy !== 1'b0 && cnt < 100) begin
      step();
      cnt++;
    end
    if (bus.busy !== 1'b0) ok = 1'b0;
    repeat (6 * SCAN_DIV + 1) step();
    for (int d = 0; d < 6; d++) begin
      cnt = 0;
      while (bus.an !== ~(6'b000001 << d) && cnt < 6 * SCAN_DIV + 2) begin
        step();
        cnt++;
      end
      if (bus.an !== ~(6'b000001 << d)) ok = 1'b0;
      frame[7*d +: 7] = bus.seg;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply_stimulus(16'd255, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.an !== 6'b111111) begin
      errors++;
      $display("[TB] FAIL reset_an got %b expected %b", bus.an, 6'b111111);
    end
    checks++;
    if (bus.seg !== BL) begin
      errors++;
      $display("[TB] FAIL reset_seg got %b expected %b", bus.seg, BL);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy got %b expected 0", bus.busy);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_decimal_255();
    logic [18:0] tr;
    logic [41:0] fr;
    bit ok;
    busy_trace(tr);
    checks++;
    if (tr !== TRACE_NORMAL) begin
      errors++;
      $display("[TB] FAIL latency_255 got %h expected %h", tr, TRACE_NORMAL);
    end
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, BL, BL, S2, S5, S5}) begin
      errors++;
      $display("[TB] FAIL frame_255 got %h ok=%0d expected %h", fr, ok, {BL, BL, BL, S2, S5, S5});
    end
  endtask

  task automatic test_scan_sequence();
    logic [5:0] prev;
    int cnt;
    prev = bus.an;
    cnt  = 0;
    while (cnt < 40) begin
      step();
      cnt++;
      if (bus.an === 6'b111110 && prev !== 6'b111110) break;
      prev = bus.an;
    end
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (!(k == 0 && c == 0)) step();
        checks++;
        if (bus.an !== ~(6'b000001 << k)) begin
          errors++;
          $display("[TB] FAIL scan_step%0d_cycle%0d got %b expected %b", k, c, bus.an, ~(6'b000001 << k));
        end
      end
    end
    step();
    checks++;
    if (bus.an !== 6'b111110) begin
      errors++;
      $display("[TB] FAIL scan_wrap got %b expected 111110", bus.an);
    end
  endtask

  task automatic test_zero_and_negative();
    logic [41:0] fr;
    bit ok;
    apply_stimulus(16'd0, 1'b1, 1'b0);
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, BL, BL, BL, BL, S0}) begin
      errors++;
      $display("[TB] FAIL frame_zero got %h ok=%0d expected %h", fr, ok, {BL, BL, BL, BL, BL, S0});
    end
    apply_stimulus(16'd5, 1'b0, 1'b0);
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {SM, BL, BL, BL, BL, S5}) begin
      errors++;
      $display("[TB] FAIL frame_minus5 got %h ok=%0d expected %h", fr, ok, {SM, BL, BL, BL, BL, S5});
    end
  endtask

  task automatic test_max_value();
    logic [41:0] fr;
    bit ok;
    apply_stimulus(16'd65535, 1'b1, 1'b0);
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, S6, S5, S5, S3, S5}) begin
      errors++;
      $display("[TB] FAIL frame_65535 got %h ok=%0d expected %h", fr, ok, {BL, S6, S5, S5, S3, S5});
    end
  endtask

  task automatic test_hex_mode();
    logic [18:0] tr;
    logic [41:0] fr;
    bit ok;
    apply_stimulus(16'hBEEF, 1'b1, 1'b1);
    busy_trace(tr);
    checks++;
    if (tr !== TRACE_NORMAL) begin
      errors++;
      $display("[TB] FAIL latency_hex got %h expected %h", tr, TRACE_NORMAL);
    end
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, BL, SB_, SE, SE, SF}) begin
      errors++;
      $display("[TB] FAIL frame_beef got %h ok=%0d expected %h", fr, ok, {BL, BL, SB_, SE, SE, SF});
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] tr;
    logic [41:0] fr;
    bit ok;
    apply_stimulus(16'd100, 1'b1, 1'b0);
    tr = '0;
    for (int n = 0; n < 19; n++) begin
      step();
      tr[n] = bus.busy;
      if (n == 2) bus.value = 16'd42;
    end
    checks++;
    if (tr !== TRACE_B2B) begin
      errors++;
      $display("[TB] FAIL busy_b2b got %h expected %h", tr, TRACE_B2B);
    end
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, BL, BL, BL, S4, S2}) begin
      errors++;
      $display("[TB] FAIL frame_42 got %h ok=%0d expected %h", fr, ok, {BL, BL, BL, BL, S4, S2});
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [18:0] tr;
    logic [41:0] fr;
    bit ok;
    apply_stimulus(16'd1234, 1'b1, 1'b0);
    repeat (9) step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.an !== 6'b111111) begin
      errors++;
      $display("[TB] FAIL midreset_an got %b expected 111111", bus.an);
    end
    checks++;
    if (bus.seg !== BL) begin
      errors++;
      $display("[TB] FAIL midreset_seg got %b expected %b", bus.seg, BL);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_busy got %b expected 0", bus.busy);
    end
    step();
    step();
    reset = 1'b0;
    busy_trace(tr);
    checks++;
    if (tr !== TRACE_NORMAL) begin
      errors++;
      $display("[TB] FAIL latency_after_reset got %h expected %h", tr, TRACE_NORMAL);
    end
    capture_frame(fr, ok);
    checks++;
    if (!ok || fr !== {BL, BL, S1, S2, S3, S4}) begin
      errors++;
      $display("[TB] FAIL frame_1234 got %h ok=%0d expected %h", fr, ok, {BL, BL, S1, S2, S3, S4});
    end
  endtask

  // Run every scenario in order, then report totals
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decimal_255();
    test_scan_sequence();
    test_zero_and_negative();
    test_max_value();
    test_hex_mode();
    test_back_to_back();
    test_reset_mid_convert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the scenarios completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
